// File: rtl/pattern_serializer_if.sv
// Handshake and serial-line bundle for pattern_serializer.
// The master drives start/data; the serializer (slave) returns ready and the serial outputs.
interface pattern_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             y;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output data,
        input  ready,
        input  y,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data,
        output ready,
        output y,
        output busy,
        output done
    );
endinterface

// File: rtl/pattern_serializer.sv
// MSB-first serial pattern transmitter with start/ready handshake.
// Back-to-back words are accepted during the last-bit cycle, so the line streams with no gap.
module pattern_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b1
) (
    input logic                clk,
    input logic                reset,
    pattern_serializer_if.slave bus
);
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             last_c;
    logic             ready_c;
    logic             accept_c;

    // State and datapath registers; reset wins over any simultaneous start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            y_q     <= IDLE_BIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        busy_d   = busy_q;
        done_d   = done_q;

        last_c   = (state_q == SHIFT) && (cnt_q == LAST);
        ready_c  = (state_q == IDLE) || last_c;
        accept_c = bus.start && ready_c;

        if (accept_c) begin
            state_d = SHIFT;
            sr_d    = bus.data;
            cnt_d   = '0;
            y_d     = bus.data[WIDTH-1];
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            if (last_c) begin
                state_d = IDLE;
                y_d     = IDLE_BIT;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
                // Rotate rather than zero-fill: wrapped bits never reach the line.
                sr_d   = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
                y_d    = sr_q[WIDTH-2];
                done_d = (cnt_d == LAST);
            end
        end
    end

    assign bus.ready = ready_c;
    assign bus.y     = y_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: per-cycle model compare plus directed literal checks.
module tb_pattern_serializer;
    localparam int unsigned W = 8;

    logic clk;
    logic reset;

    pattern_serializer_if #(.WIDTH(W)) bus ();

    pattern_serializer #(
        .WIDTH   (W),
        .IDLE_BIT(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pos is the index of the data bit currently on the line, -1 when idle.
    logic [W-1:0] m_word  = '0;
    int           m_pos   = -1;
    logic         m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pos   = -1;
            m_valid = 1'b1;
        end else if (bus.start && m_pos <= 0) begin
            m_word = bus.data;
            m_pos  = W - 1;
        end else if (m_pos >= 0) begin
            m_pos = m_pos - 1;
        end
    end

    always @(negedge clk) begin
        logic exp_y;
        if (m_valid) begin
            exp_y = 1'b1;
            if (m_pos >= 0) exp_y = m_word[m_pos];
            chk("model_y",     32'(bus.y),     32'(exp_y));
            chk("model_busy",  32'(bus.busy),  32'(m_pos >= 0));
            chk("model_done",  32'(bus.done),  32'(m_pos == 0));
            chk("model_ready", 32'(bus.ready), 32'(m_pos <= 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample n cycles (cycle 1 first); optional input changes at cycles c1 and c2.
    task automatic capture(input int n,
                           input int c1, input logic s1, input logic [W-1:0] d1,
                           input int c2, input logic s2, input logic [W-1:0] d2,
                           output logic [31:0] bits, output logic [31:0] dm,
                           output logic [31:0] bm);
        bits = '0;
        dm   = '0;
        bm   = '0;
        for (int k = 1; k <= n; k++) begin
            if (k == c1) begin bus.start = s1; bus.data = d1; end
            if (k == c2) begin bus.start = s2; bus.data = d2; end
            @(negedge clk);
            bits = {bits[30:0], bus.y};
            dm   = {dm[30:0], bus.done};
            bm   = {bm[30:0], bus.busy};
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        chk({name, "_y"},     32'(bus.y),     32'd1);
        chk({name, "_ready"}, 32'(bus.ready), 32'd1);
        chk({name, "_busy"},  32'(bus.busy),  32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] bits, dm, bm;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.data  = '0;

        // Reset values
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_y",     32'(bus.y),     32'd1);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_done",  32'(bus.done),  32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        tick();

        // Single word A5
        bus.start = 1'b1; bus.data = 8'hA5;
        tick();
        bus.start = 1'b0;
        capture(8, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00, bits, dm, bm);
        chk("a5_bits", bits, 32'h0000_00A5);
        chk("a5_done", dm,   32'h0000_0001);
        chk("a5_busy", bm,   32'h0000_00FF);
        idle_check("a5_after");

        // Back-to-back F0 then 0F
        bus.start = 1'b1; bus.data = 8'hF0;
        tick();
        capture(16, 8, 1'b1, 8'h0F, 9, 1'b0, 8'h0F, bits, dm, bm);
        chk("b2b_bits", bits, 32'h0000_F00F);
        chk("b2b_done", dm,   32'h0000_0101);
        chk("b2b_busy", bm,   32'h0000_FFFF);
        idle_check("b2b_after");

        // Ignored start during cycle 3
        bus.start = 1'b1; bus.data = 8'h81;
        tick();
        bus.start = 1'b0;
        capture(8, 3, 1'b1, 8'h00, 4, 1'b0, 8'h00, bits, dm, bm);
        chk("ign_bits", bits, 32'h0000_0081);
        chk("ign_done", dm,   32'h0000_0001);
        idle_check("ign_after");

        // Reset mid-word
        bus.start = 1'b1; bus.data = 8'hFF;
        tick();
        bus.start = 1'b0;
        capture(3, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00, bits, dm, bm);
        reset = 1'b1;
        capture(1, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00, bits, dm, bm);
        reset = 1'b0;
        capture(3, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00, bits, dm, bm);
        chk("rmid_bits", bits, 32'h0000_0007);
        chk("rmid_busy", bm,   32'h0000_0000);
        chk("rmid_done", dm,   32'h0000_0000);
        bus.start = 1'b1; bus.data = 8'h3C;
        tick();
        bus.start = 1'b0;
        capture(8, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00, bits, dm, bm);
        chk("post_rst_bits", bits, 32'h0000_003C);
        chk("post_rst_done", dm,   32'h0000_0001);

        // Reset and start together
        reset = 1'b1; bus.start = 1'b1; bus.data = 8'hAA;
        tick();
        reset = 1'b0; bus.start = 1'b0;
        capture(9, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00, bits, dm, bm);
        chk("coll_bits", bits, 32'h0000_01FF);
        chk("coll_busy", bm,   32'h0000_0000);
        idle_check("coll_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Serial pattern transmitter: accepts a parallel word on a start/ready handshake and emits it MSB-first, one bit per clock, on a single-bit serial line. It is the driving end of the single-bit serial pattern link and feeds the team's serial pattern detectors. The line sits at a fixed idle level between words. Back-to-back words stream with no gap.

## Interface
Parameters:
- WIDTH, 8 — bits per word; legal range WIDTH ≥ 2.
- IDLE_BIT, 1'b1 — level driven on `y` when no word is being sent.

Ports:
- clk  input  1  — single clock; all logic on rising edge.
- reset  input  1  — synchronous, active-high; sampled on rising edge of clk.
- start  input  1  — request to send `data`; accepted only when `ready`=1.
- data  input  WIDTH  — word to send; sampled on the accepting edge only.
- ready  output  1  — block can accept `start` this cycle.
- y  output  1  — serial line, registered.
- busy  output  1  — registered; 1 while `y` carries a data bit.
- done  output  1  — registered; 1-cycle pulse while the last bit (data[0]) is on `y`.

## Operation
- Two states: IDLE, SHIFT. Internal registers: WIDTH-bit shift register `sr`, bit counter `cnt` of width $clog2(WIDTH), starting at 0.
- `ready` is combinational and has one of two forms:
  - in IDLE: `ready` = 1;
  - in SHIFT: `ready` = (cnt == WIDTH-1), i.e. high during the last-bit cycle only.
- Accept event: `start` & `ready` at a rising edge. On that edge:
  - `sr` ← `data`;
  - `cnt` ← 0;
  - state ← SHIFT;
  - `y` ← data[WIDTH-1];
  - `busy` ← 1;
  - `done` ← (WIDTH==1 ? n/a : 0).
- In SHIFT with no accept, on each edge:
  - if `cnt` < WIDTH-1: `cnt` increments, `sr` shifts left by one, and `y` takes the next bit. `done` ← 1 when the new `cnt` == WIDTH-1.
  - if `cnt` == WIDTH-1: state ← IDLE, `y` ← IDLE_BIT, `busy` ← 0, `done` ← 0.
- Start during the last-bit cycle (SHIFT, `cnt`==WIDTH-1, `start`=1): this is a normal accept. The new word's MSB appears on the next cycle, with no idle gap; `busy` stays 1 and `done` returns to 0.
- `start` while `ready`=0 is ignored. It is not queued, and `data` is not sampled.
- `start` in IDLE with `data` changing later has no effect on the word in flight.
- Reset (synchronous, priority over everything, including a simultaneous `start`):
  - state ← IDLE, `cnt` ← 0, `sr` ← 0;
  - `y` ← IDLE_BIT, `busy` ← 0, `done` ← 0.
  - `ready` = 1 in the cycle after the reset edge.
- Reset mid-word aborts the transfer: the remaining bits are never sent and no `done` pulse occurs.

## Timing
- Latency: accept edge at cycle 0 → data[WIDTH-1] on `y` during cycle 1 → data[0] on `y` during cycle WIDTH.
- `done` is high exactly during cycle WIDTH. `busy` is high during cycles 1..WIDTH.
- After WIDTH cycles with no new accept, `y` returns to IDLE_BIT in cycle WIDTH+1 and `ready` goes high.
- Sustained throughput: one word per WIDTH cycles when `start` is held high.
- All outputs except `ready` are registered. `ready` depends only on registered state, with no combinational path from `start` or `data`.

## Test plan
- **Reset values:** assert `reset` for 2 cycles, then release. Require y=IDLE_BIT(1), busy=0, done=0, ready=1.
- **Single word, WIDTH=8:** start=1 with data=8'hA5 for one cycle in IDLE. Require:
  - `y` over cycles 1..8 = 1,0,1,0,0,1,0,1;
  - busy=1 in cycles 1..8;
  - done=1 only in cycle 8;
  - y=1, ready=1 in cycle 9.
- **Back-to-back:** hold start=1, present 8'hF0 and then 8'h0F (switch `data` in the cycle `ready` goes high in SHIFT). Require:
  - 16 consecutive bits 11110000_00001111 with no idle cycle;
  - `done` pulses in cycles 8 and 16;
  - busy stays 1 through cycle 16.
- **Ignored start:** send 8'h81, then pulse start with data=8'h00 during cycle 3. Require the serial output to remain 1,0,0,0,0,0,0,1, and the block to return to IDLE after cycle 8.
- **Reset mid-word:** send 8'hFF and assert reset at the edge ending cycle 4. Require:
  - y=IDLE_BIT, busy=0, done=0 from the next cycle;
  - no `done` pulse;
  - a following word 8'h3C is then transmitted correctly.
- **Reset vs start collision:** assert reset and start together with data=8'hAA. Require no word to be sent, y=IDLE_BIT, and ready=1 afterwards.
